// File: rtl/count_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : count_seq_pkg                                                   |
// | Purpose  : Shared state encoding and default sizing for count_sequencer.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package count_seq_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_INIT  = 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/count_core.sv
// +----------------------------------------------------------------------------+
// | Module   : count_core                                                      |
// | Purpose  : Loadable up-counter with enable; load has priority over enable. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module count_core
    import count_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

`default_nettype wire

// File: rtl/count_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module   : count_sequencer                                                 |
// | Purpose  : Start/pause/abort controlled count window around count_core.    |
// |            COUNT_SEQ_AUTO_RELOAD_EN: DONE restarts the run instead of idling|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int INIT  = DEF_INIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             core_load;
    logic [WIDTH-1:0] core_load_val;
    logic             core_en;

    always_comb begin
        state_d       = state_q;
        lim_d         = lim_q;
        core_load     = 1'b0;
        core_load_val = INIT_V;
        core_en       = 1'b0;

        if (abort) begin
            // An idle abort also swallows a coincident start.
            if (state_q != S_IDLE) begin
                state_d       = S_IDLE;
                core_load     = 1'b1;
                core_load_val = '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        lim_d     = limit;
                        core_load = 1'b1;
                        state_d   = (limit == INIT_V) ? S_DONE : S_RUN;
                    end
                end
                S_RUN, S_PAUSE: begin
                    // Terminal value is held for one cycle before DONE, so done trails q==lim.
                    if (pause) begin
                        state_d = S_PAUSE;
                    end else if (q == lim_q) begin
                        state_d = S_DONE;
                    end else begin
                        core_en = 1'b1;
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
`ifdef COUNT_SEQ_AUTO_RELOAD_EN
                    core_load = 1'b1;
                    state_d   = S_RUN;
`else
                    state_d   = S_IDLE;
`endif
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

`ifdef COUNT_SEQ_AUTO_RELOAD_EN
        busy_d = (state_d != S_IDLE);
`else
        busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
`endif
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            lim_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .load_val (core_load_val),
        .en       (core_en),
        .q        (q)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

`default_nettype wire
